// File: rtl/systolic_writeback_pkg.sv
// Shared types and defaults for the systolic result drain.
// Imported by the drain top and its clamp.
package systolic_writeback_pkg;

  localparam int ADD_WIDTH_D  = 6;
  localparam int ROW_D        = 4;
  localparam int COL_D        = 4;
  localparam int ACC_WIDTH_D  = 32;
  localparam int DATA_WIDTH_D = 16;
  localparam int BASE_ADDR_D  = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic longint sat_max(int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter.sv
// Wrapping up-counter with enable, sync clear and carry-out.
// Carry fires on the enabled cycle that wraps from MAX to 0.
module counter #(
  parameter int          W   = 2,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         co
);

  assign co = en && (q == MAX);

  // Count on enable, wrap at MAX, clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= co ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/systolic_writeback_sat_trunc.sv
// Signed clamp of an accumulator value to the RAM word width.
// ovf flags any value that had to be clamped.
import systolic_writeback_pkg::*;

module sat_trunc #(
  parameter int AW = ACC_WIDTH_D,
  parameter int DW = DATA_WIDTH_D
) (
  input  logic [AW-1:0] acc,
  output logic [DW-1:0] dat,
  output logic          ovf
);

  localparam logic signed [AW-1:0] HI = AW'(sat_max(DW));
  localparam logic signed [AW-1:0] LO = AW'(sat_min(DW));

  logic hi_ovf;
  logic lo_ovf;

  assign hi_ovf = $signed(acc) > HI;
  assign lo_ovf = $signed(acc) < LO;
  assign ovf    = hi_ovf || lo_ovf;

  // Clamp out-of-range values; in-range truncation is exact.
  always_comb begin
    dat = acc[DW-1:0];
    unique case (1'b1)
      hi_ovf:  dat = HI[DW-1:0];
      lo_ovf:  dat = LO[DW-1:0];
      default: dat = acc[DW-1:0];
    endcase
  end

endmodule

// File: rtl/systolic_writeback.sv
// Drains ROW x COL array results column by column into RAM.
// Each result is clamped to the RAM word and written serially.
import systolic_writeback_pkg::*;

module systolic_writeback #(
  parameter int ADD_WIDTH  = ADD_WIDTH_D,
  parameter int ROW        = ROW_D,
  parameter int COL        = COL_D,
  parameter int ACC_WIDTH  = ACC_WIDTH_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int BASE_ADDR  = BASE_ADDR_D,
  localparam int AW = ADD_WIDTH + 1,
  localparam int SW = $clog2(ROW * COL + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ROW*ACC_WIDTH-1:0] acc_col,
  output logic                     shift_out,
  input  logic                     ram_busy,
  output logic [AW-1:0]            add_c,
  output logic [DATA_WIDTH-1:0]    din_c,
  output logic                     w_c,
  output logic                     busy,
  output logic                     done,
  output logic [SW-1:0]            sat_cnt
);

  localparam int RW = cnt_w(ROW);
  localparam int CW = cnt_w(COL);

  state_t                 state;
  logic [RW-1:0]          row;
  logic [CW-1:0]          col;
  logic                   row_co;
  logic                   col_co;
  logic                   wr_acc;
  logic                   ovf;
  logic [ACC_WIDTH-1:0]   buf_q [ROW];

  assign wr_acc = (state == S_WRITE) && !ram_busy;
  assign w_c    = wr_acc;
  assign add_c  = AW'(BASE_ADDR)
                + AW'(col) * AW'(ROW)
                + AW'(row);

  counter #(
    .W   (RW),
    .MAX (RW'(ROW - 1))
  ) u_row (
    .clk (clk),
    .rst (rst),
    .clr (state == S_CAPTURE),
    .en  (wr_acc),
    .q   (row),
    .co  (row_co)
  );

  counter #(
    .W   (CW),
    .MAX (CW'(COL - 1))
  ) u_col (
    .clk (clk),
    .rst (rst),
    .clr ((state == S_IDLE) && start),
    .en  (row_co),
    .q   (col),
    .co  (col_co)
  );

  sat_trunc #(
    .AW (ACC_WIDTH),
    .DW (DATA_WIDTH)
  ) u_sat (
    .acc (buf_q[row]),
    .dat (din_c),
    .ovf (ovf)
  );

  // Latch the presented column while the array is told to advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROW; r++) buf_q[r] <= '0;
    end else if (state == S_CAPTURE) begin
      for (int r = 0; r < ROW; r++)
        buf_q[r] <= acc_col[r*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  // Drain sequencing with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      shift_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat_cnt   <= '0;
    end else begin
      shift_out <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CAPTURE;
            shift_out <= 1'b1;
            busy      <= 1'b1;
            sat_cnt   <= '0;
          end
        end
        S_CAPTURE: begin
          state <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_acc) begin
            if (ovf) sat_cnt <= sat_cnt + SW'(1);
            if (col_co) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (row_co) begin
              state     <= S_CAPTURE;
              shift_out <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_writeback.sv
// Directed bench for the systolic result drain.
// A small array model feeds columns; writes are scoreboarded.
module tb_systolic_writeback;

  logic          clk;
  logic          rst;
  logic          start;
  logic [127:0]  acc_col;
  logic          shift_out;
  logic          ram_busy;
  logic [6:0]    add_c;
  logic [15:0]   din_c;
  logic          w_c;
  logic          busy;
  logic          done;
  logic [4:0]    sat_cnt;

  int n_checks;
  int n_errors;

  longint mat [4][4];
  int     col_idx;
  bit     pend;
  int     wr_addr [$];
  int     wr_data [$];
  int     shift_cyc [$];
  int     done_cyc;
  int     done_cnt;

  systolic_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .acc_col   (acc_col),
    .shift_out (shift_out),
    .ram_busy  (ram_busy),
    .add_c     (add_c),
    .din_c     (din_c),
    .w_c       (w_c),
    .busy      (busy),
    .done      (done),
    .sat_cnt   (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic drive_col();
    for (int r = 0; r < 4; r++)
      acc_col[r*32 +: 32] = (col_idx < 4) ? 32'(mat[col_idx][r]) : '0;
  endtask

  task automatic set_plain();
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        mat[c][r] = c * 4 + r + 1;
  endtask

  task automatic set_sat();
    set_plain();
    mat[0][0] = 65536;
    mat[0][1] = -70000;
    mat[0][2] = -32768;
    mat[0][3] = 32767;
  endtask

  task automatic drain(input int b_from, input int b_len,
                       input int stall_addr, input int s1,
                       input int s2, input int rst_at,
                       input int ncyc);
    wr_addr.delete();
    wr_data.delete();
    shift_cyc.delete();
    done_cyc = -1;
    done_cnt = 0;
    col_idx  = 0;
    pend     = 1'b0;
    @(posedge clk);
    #1;
    drive_col();
    start = 1'b1;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(posedge clk);
      #1;
      if (pend) begin
        col_idx++;
        pend = 1'b0;
      end
      start    = (cyc == s1) || (cyc == s2);
      ram_busy = (cyc >= b_from) && (cyc < b_from + b_len);
      if (cyc == rst_at) begin
        rst     = 1'b1;
        col_idx = 0;
      end
      if (cyc == rst_at + 3) rst = 1'b0;
      drive_col();
      #1;
      if (cyc == rst_at) begin
        check("rst_shift", shift_out, 0);
        check("rst_wc", w_c, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", add_c, 32);
        check("rst_din", din_c, 0);
        check("rst_sat", sat_cnt, 0);
      end
      if (cyc == 1) check("busy_on", busy, 1);
      if (ram_busy) begin
        check("stall_wc", w_c, 0);
        check("stall_addr", add_c, stall_addr);
      end
      if (w_c) begin
        wr_addr.push_back(int'(add_c));
        wr_data.push_back(int'(din_c));
      end
      if (shift_out) begin
        shift_cyc.push_back(cyc);
        pend = 1'b1;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    start    = 1'b0;
    ram_busy = 1'b0;
  endtask

  task automatic verify(input string t, input int exp_done,
                        input int exp_sat, input int stall_col,
                        input int stall_len);
    logic [15:0] e;
    check({t, "_nwr"}, wr_addr.size(), 16);
    if (wr_addr.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        e = 16'(clamp(mat[i / 4][i % 4]));
        check({t, "_addr"}, wr_addr[i], 32 + i);
        check({t, "_data"}, wr_data[i], int'(e));
      end
    end
    check({t, "_nshift"}, shift_cyc.size(), 4);
    if (shift_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++)
        check({t, "_shift"}, shift_cyc[i],
              1 + 5 * i + ((i > stall_col) ? stall_len : 0));
    end
    check({t, "_done_cyc"}, done_cyc, exp_done);
    check({t, "_done_cnt"}, done_cnt, 1);
    check({t, "_sat_cnt"}, sat_cnt, exp_sat);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    start    = 1'b0;
    ram_busy = 1'b0;
    col_idx  = 0;
    set_plain();
    drive_col();

    @(posedge clk);
    #1;
    check("reset_shift", shift_out, 0);
    check("reset_wc", w_c, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", add_c, 32);
    check("reset_din", din_c, 0);
    check("reset_sat", sat_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    set_plain();
    drain(0, 0, 0, 0, 0, 1000, 21);
    verify("basic", 21, 0, 99, 0);
    @(posedge clk);
    #2;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    set_sat();
    drain(0, 0, 0, 0, 0, 1000, 21);
    verify("sat", 21, 2, 99, 0);
    if (wr_data.size() >= 4) begin
      check("sat_w0", wr_data[0], 16'h7FFF);
      check("sat_w1", wr_data[1], 16'h8000);
      check("sat_w2", wr_data[2], 16'h8000);
      check("sat_w3", wr_data[3], 16'h7FFF);
    end

    set_plain();
    drain(9, 3, 38, 0, 0, 1000, 24);
    verify("stall", 24, 0, 1, 3);

    set_sat();
    drain(0, 0, 0, 13, 21, 1000, 21);
    verify("startbusy", 21, 2, 99, 0);
    set_plain();
    drain(0, 0, 0, 0, 0, 1000, 21);
    verify("restart", 21, 0, 99, 0);

    set_plain();
    drain(0, 0, 0, 0, 0, 6, 20);
    check("midrst_nwr", wr_addr.size(), 4);
    check("midrst_done", done_cnt, 0);
    check("midrst_busy", busy, 0);
    drain(0, 0, 0, 0, 0, 1000, 21);
    verify("after_rst", 21, 0, 99, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
